// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared constants and state encoding for the fetch stage
package fetch_stage_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  typedef enum logic {FETCH = 1'b0, HALT = 1'b1} fetch_state_e;
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// fetch_stage_if_id_reg: IF/ID pipeline register with hold and flush
module fetch_stage_if_id_reg import fetch_stage_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        flush,
  input  logic        load,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc4_in,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc4
);
  logic        valid_q, valid_d, take;
  logic [31:0] instr_q, instr_d, pc4_q, pc4_d;
  assign take = load && !hold && !flush;
  always_comb begin
    valid_d = flush ? 1'b0 : take ? 1'b1 : valid_q;
    instr_d = flush ? NOP_INSTR : take ? instr_in : instr_q;
    pc4_d   = take ? pc4_in : pc4_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end
  assign valid = valid_q;
  assign instr = instr_q;
  assign pc4   = pc4_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, fetch/halt FSM and imem handshake feeding the IF/ID register
module fetch_stage import fetch_stage_pkg::*; #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  input  logic             sys_halt,
  output logic             if_id_valid,
  output logic [31:0]      if_id_instr,
  output logic [31:0]      if_id_pc4,
  output logic [5:0]       opcode,
  output logic [5:0]       func,
  output logic             fetch_err,
  output logic [CNT_W-1:0] fetch_count
);
  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fetching, accept, bad_tgt, flush;
  assign fetching  = state_q == FETCH;
  assign imem_req  = fetching && !stall && !redirect_valid && !sys_halt;
  assign imem_addr = pc_q;
  assign accept    = imem_req && imem_ready;
  assign bad_tgt   = redirect_pc[1:0] != 2'b00;
  // HALT keeps flushing so IF/ID can never pick up a word after termination
  assign flush = !fetching || sys_halt || redirect_valid || (imem_req && !imem_ready);
  always_comb begin
    state_d = (fetching && (sys_halt || (redirect_valid && bad_tgt))) ? HALT : state_q;
    pc_d    = (!fetching || sys_halt) ? pc_q
            : redirect_valid ? (bad_tgt ? pc_q : redirect_pc)
            : accept ? pc_q + 32'd4 : pc_q;
    err_d   = err_q || (fetching && !sys_halt && redirect_valid && bad_tgt);
    cnt_d   = accept ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  fetch_stage_if_id_reg u_if_id (
    .clk     (clk),
    .rst     (rst),
    .hold    (stall),
    .flush   (flush),
    .load    (accept),
    .instr_in(imem_rdata),
    .pc4_in  (pc_q + 32'd4),
    .valid   (if_id_valid),
    .instr   (if_id_instr),
    .pc4     (if_id_pc4)
  );
  assign opcode      = if_id_instr[31:26];
  assign func        = if_id_instr[5:0];
  assign fetch_err   = err_q;
  assign fetch_count = cnt_q;
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode control unit.
- Holds the PC, drives instruction memory through a req/ready handshake, and applies stall, redirect (branch/j/jal/jr) and halt (syscall exit).
- Presents the fetched word, its PC+4, and the opcode/func slices that decode consumes.
- No branch delay slot: a redirect squashes the instruction in IF.

Parameters:
- RESET_PC, 32'h0040_0000, first fetch address after reset (text segment base).
- CNT_W, 32, width of the fetch performance counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request; the address is valid while high
- imem_addr  out  32  word-aligned fetch address (equals pc)
- imem_ready  in  1  memory accepts the request; imem_rdata is valid in the same cycle
- imem_rdata  in  32  instruction word
- stall  in  1  hazard unit: hold PC and IF/ID
- redirect_valid  in  1  decode resolved a taken branch, j, jal or jr
- redirect_pc  in  32  target address
- sys_halt  in  1  syscall exit seen in decode
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_instr  out  32  instruction word to decode (0 = sll NOP when invalid)
- if_id_pc4  out  32  PC+4 of the IF/ID instruction (used for jal link and branch base)
- opcode  out  6  if_id_instr[31:26], combinational slice
- func  out  6  if_id_instr[5:0], combinational slice
- fetch_err  out  1  sticky flag: misaligned redirect target
- fetch_count  out  CNT_W  number of instructions loaded into IF/ID

Behaviour:
- Reset (sync, rst=1 at a rising edge):
  - State and outputs: state=FETCH, pc=RESET_PC, if_id_valid=0, if_id_instr=0, if_id_pc4=0, fetch_err=0, fetch_count=0.
  - rst overrides every other input in the same cycle, including mid-wait and in HALT.
- States:
  - FETCH: normal operation.
  - HALT: terminal until rst.
- Request generation (combinational):
  - imem_req = (state==FETCH) && !stall && !redirect_valid && !sys_halt.
  - imem_addr = pc at all times.
- Per-cycle priority (highest first): rst, sys_halt, redirect_valid, stall, accept, wait.
- sys_halt: state becomes HALT; if_id_valid=0; if_id_instr=0; pc holds.
- redirect_valid:
  - If redirect_pc[1:0]!=0: fetch_err=1, state becomes HALT, IF/ID is flushed.
  - Otherwise: pc=redirect_pc, if_id_valid=0, if_id_instr=0. This is a one-bubble penalty.
  - Any in-flight wait is abandoned; memory must tolerate the address change.
- stall (no redirect, no halt): pc, IF/ID and fetch_count all hold; no request is issued.
- Accept (imem_req && imem_ready):
  - if_id_instr=imem_rdata, if_id_pc4=pc+4, if_id_valid=1, pc=pc+4.
  - fetch_count increments and wraps modulo 2^CNT_W.
  - Latency: address in cycle N, instruction visible to decode in cycle N+1. Sustained throughput is 1/cycle with a zero-wait memory.
- Wait (imem_req && !imem_ready): pc holds; a bubble is inserted (if_id_valid=0, if_id_instr=0).
- Arithmetic: pc+4 is a 32-bit add; wrap from 32'hFFFF_FFFC to 0 is permitted and not flagged.
- HALT: imem_req=0; IF/ID stays invalid; stall and redirect are ignored; fetch_err holds.
- opcode and func always slice if_id_instr, so an invalid slot decodes as SPECIAL/SLL with regWrite=0.

Decomposition:
- Add to mips.h:
  - `NOP_INSTR 32'h0000_0000
  - `RESET_PC default
  - FETCH/HALT state encodings (1 bit)
- Natural sub-module: if_id_reg, the IF/ID register with hold (stall) and flush (redirect/halt/bubble) inputs.
- Keep the PC register and FSM in fetch_stage.

Test Plan:
- Reset then imem_ready=1, memory returns 32'h2008_0005 at 0x00400000 -> cycle after first accept: if_id_valid=1, opcode=6'h08, if_id_pc4=32'h0040_0004, fetch_count=1.
- imem_ready low for 3 cycles at pc=0x00400008 -> imem_addr stays 0x00400008, three bubbles with if_id_instr=0, then normal accept.
- stall=1 for 2 cycles with if_id_instr=32'h8C09_0000 -> IF/ID, pc and fetch_count unchanged; imem_req=0.
- redirect_valid=1 with redirect_pc=0x00400040, same cycle as stall=1 -> next cycle pc=0x00400040, if_id_valid=0; following fetch at 0x00400040.
- redirect_pc=0x00400042 -> fetch_err=1, state HALT, imem_req=0 forever; stall/redirect are ignored; rst clears fetch_err and restarts at RESET_PC.
- sys_halt pulse while imem_ready=1 -> no accept that cycle, if_id_valid=0; fetch_count frozen; rst asserted in HALT resumes fetching.
